// File: rtl/arbiter_puf_pkg.sv
// rtl/arbiter_puf_pkg.sv - shared types, constants and vote helper for the PUF response collector
//
// Contents:
//   state_t          collector FSM states
//   TAP_MASK_DEFAULT default LFSR feedback taps (bits 63,62,60,59)
//   majority()       voted bit from a ones count and the number of votes
package arbiter_puf_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_SETTLE,
    S_SAMPLE,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [63:0] TAP_MASK_DEFAULT = 64'hD800_0000_0000_0000;

  // With an odd vote count there is never a tie.
  function automatic logic majority(input int unsigned count, input int unsigned votes);
    return count > (votes / 2);
  endfunction

endpackage

// File: rtl/puf_bit_sync.sv
// rtl/puf_bit_sync.sv - two-flop synchronizer for the asynchronous arbiter output
//
// Ports:
//   clk  in   clock
//   rst  in   synchronous active-high reset, clears both stages to 0
//   d    in   asynchronous input
//   q    out  second-stage (synchronized) output
module puf_bit_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/puf_response_collector.sv
// rtl/puf_response_collector.sv - arbiter PUF challenge generator, vote sampler and response packer
//
// Ports:
//   iclk    in   clock
//   irst    in   synchronous active-high reset
//   istart  in   request pulse, accepted only when idle
//   iseed   in   initial challenge, captured on an accepted istart
//   ibit    in   arbiter output (asynchronous, synchronized internally)
//   ochal   out  current challenge driven to the delay chains
//   olaunch out  one-cycle race launch pulse
//   oresp   out  collected response word, first bit in the MSB
//   ovalid  out  one-cycle pulse marking a new oresp
//   obusy   out  high whenever a request is in progress
module puf_response_collector
  import arbiter_puf_pkg::*;
#(
  parameter int                CHAL_W   = 64,
  parameter int                RESP_W   = 32,
  parameter int                VOTES    = 5,
  parameter int                SETTLE   = 4,
  parameter logic [CHAL_W-1:0] TAP_MASK = CHAL_W'(TAP_MASK_DEFAULT)
) (
  input  logic              iclk,
  input  logic              irst,
  input  logic              istart,
  input  logic [CHAL_W-1:0] iseed,
  input  logic              ibit,
  output logic [CHAL_W-1:0] ochal,
  output logic              olaunch,
  output logic [RESP_W-1:0] oresp,
  output logic              ovalid,
  output logic              obusy
);

  localparam int VW = $clog2(VOTES + 1);
  localparam int SW = $clog2(SETTLE + 1);
  localparam int BW = $clog2(RESP_W + 1);

  state_t            state;
  logic [SW-1:0]     settle_cnt;
  logic [VW-1:0]     vote_cnt;
  logic [VW-1:0]     ones_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [RESP_W-1:0] shreg;
  logic              bit_sync;

  logic [VW-1:0]     vote_next;
  logic [RESP_W-1:0] shreg_next;
  logic [CHAL_W-1:0] chal_next;

  puf_bit_sync u_bit_sync (
    .clk (iclk),
    .rst (irst),
    .d   (ibit),
    .q   (bit_sync)
  );

  assign vote_next  = vote_cnt + VW'(1);
  assign shreg_next = {shreg[RESP_W-2:0], majority(32'(ones_cnt), VOTES)};
  assign chal_next  = {ochal[CHAL_W-2:0], ^(ochal & TAP_MASK)};

  // olaunch and ovalid are asserted on the transition into LAUNCH / DONE so
  // that they are registered and coincide exactly with those states.
  always_ff @(posedge iclk) begin
    if (irst) begin
      state      <= S_IDLE;
      ochal      <= '0;
      olaunch    <= 1'b0;
      oresp      <= '0;
      ovalid     <= 1'b0;
      obusy      <= 1'b0;
      settle_cnt <= '0;
      vote_cnt   <= '0;
      ones_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
    end else begin
      olaunch <= 1'b0;
      ovalid  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (istart) begin
            // An all-zero seed would lock the LFSR, so substitute 1.
            ochal    <= (iseed == '0) ? CHAL_W'(1) : iseed;
            vote_cnt <= '0;
            ones_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            olaunch  <= 1'b1;
            obusy    <= 1'b1;
            state    <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          settle_cnt <= '0;
          state      <= S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_cnt == SW'(SETTLE - 1)) begin
            state <= S_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        S_SAMPLE: begin
          ones_cnt <= ones_cnt + VW'(bit_sync);
          vote_cnt <= vote_next;
          if (vote_next < VW'(VOTES)) begin
            olaunch <= 1'b1;
            state   <= S_LAUNCH;
          end else begin
            state <= S_NEXT;
          end
        end
        S_NEXT: begin
          shreg    <= shreg_next;
          ochal    <= chal_next;
          vote_cnt <= '0;
          ones_cnt <= '0;
          if (bit_cnt == BW'(RESP_W - 1)) begin
            oresp  <= shreg_next;
            ovalid <= 1'b1;
            state  <= S_DONE;
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
            olaunch <= 1'b1;
            state   <= S_LAUNCH;
          end
        end
        S_DONE: begin
          obusy <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_response_collector.sv
// tb/tb_puf_response_collector.sv - scoreboard bench for puf_response_collector
module tb_puf_response_collector;

  localparam int CHAL_W = 64;
  localparam int RESP_W = 4;
  localparam int VOTES  = 3;
  localparam int SETTLE = 3;
  localparam int LAT    = 65;
  localparam int NV     = RESP_W * VOTES;

  logic              iclk;
  logic              irst;
  logic              istart;
  logic [CHAL_W-1:0] iseed;
  logic              ibit;
  logic [CHAL_W-1:0] ochal;
  logic              olaunch;
  logic [RESP_W-1:0] oresp;
  logic              ovalid;
  logic              obusy;

  puf_response_collector #(
    .CHAL_W (CHAL_W),
    .RESP_W (RESP_W),
    .VOTES  (VOTES),
    .SETTLE (SETTLE)
  ) dut (
    .iclk    (iclk),
    .irst    (irst),
    .istart  (istart),
    .iseed   (iseed),
    .ibit    (ibit),
    .ochal   (ochal),
    .olaunch (olaunch),
    .oresp   (oresp),
    .ovalid  (ovalid),
    .obusy   (obusy)
  );

  initial begin
    iclk = 1'b0;
    forever #5 iclk = ~iclk;
  end

  int cyc = 0;
  always @(posedge iclk) cyc <= cyc + 1;

  typedef struct {
    logic [RESP_W-1:0] resp;
    int                cycle;
  } exp_t;

  exp_t              exp_q[$];
  int                n_tests = 0;
  int                n_fail  = 0;
  bit                vote_seq[NV];
  logic [CHAL_W-1:0] chal_seq[RESP_W];
  logic [RESP_W-1:0] model_resp;
  int                vote_idx = 0;
  int                start_cyc = 0;
  int                launches = 0;
  int                busy_cnt = 0;
  int                first_busy = -1;
  int                last_busy = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Fibonacci LFSR step written from the tap list: bits 63,62,60,59.
  function automatic logic [63:0] lfsr_step(input logic [63:0] c);
    return {c[62:0], c[63] ^ c[62] ^ c[60] ^ c[59]};
  endfunction

  // kind: 0 all zero, 1 all one, 2 pattern 110/001 alternating, 3 random
  task automatic prepare(input logic [63:0] seed, input int kind);
    int ones;
    for (int i = 0; i < NV; i++) begin
      case (kind)
        0: vote_seq[i] = 1'b0;
        1: vote_seq[i] = 1'b1;
        2: vote_seq[i] = (((i / VOTES) % 2) == 0) ? ((i % VOTES) != 2) : ((i % VOTES) == 2);
        default: vote_seq[i] = 1'($urandom_range(0, 1));
      endcase
    end
    model_resp = '0;
    for (int b = 0; b < RESP_W; b++) begin
      ones = 0;
      for (int v = 0; v < VOTES; v++) ones += int'(vote_seq[b * VOTES + v]);
      model_resp[RESP_W - 1 - b] = (2 * ones > VOTES);
    end
    chal_seq[0] = (seed == 64'h0) ? 64'h1 : seed;
    for (int b = 1; b < RESP_W; b++) chal_seq[b] = lfsr_step(chal_seq[b - 1]);
  endtask

  // Issue a request; the expected response is queued at issue time.
  task automatic issue(input logic [63:0] seed, input bit expect_done, input logic [RESP_W-1:0] resp);
    @(negedge iclk);
    iseed      = seed;
    istart     = 1'b1;
    vote_idx   = 0;
    launches   = 0;
    busy_cnt   = 0;
    first_busy = -1;
    last_busy  = -1;
    start_cyc  = cyc;
    if (expect_done) exp_q.push_back('{resp: resp, cycle: cyc + LAT});
    @(negedge iclk);
    istart = 1'b0;
    check("ochal_first", ochal, chal_seq[0]);
  endtask

  task automatic wait_done(input int repulse_at);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge iclk);
      if (repulse_at > 0 && cyc == start_cyc + repulse_at) begin
        istart = 1'b1;
        iseed  = 64'hFFFF_0000_1234_5678;
      end else begin
        istart = 1'b0;
      end
      if (!obusy && cyc > start_cyc + 1) done = 1'b1;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: obusy still high after 300 cycles, required low");
    end
    check("launch_count", 64'(launches), 64'(NV));
    check("busy_cycles", 64'(busy_cnt), 64'(LAT));
    check("busy_first", 64'(first_busy), 64'(start_cyc + 1));
    check("busy_last", 64'(last_busy), 64'(start_cyc + LAT));
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  // ibit driver: one value per launch, changed during the LAUNCH cycle.
  always @(negedge iclk) begin
    if (olaunch) begin
      if (vote_idx < NV) begin
        check("ochal_at_launch", ochal, chal_seq[vote_idx / VOTES]);
        ibit = vote_seq[vote_idx];
        vote_idx++;
      end else begin
        n_tests++;
        n_fail++;
        $display("FAIL extra_launch: launch %0d, required at most %0d", vote_idx + 1, NV);
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents ovalid.
  always @(negedge iclk) begin
    exp_t e;
    if (olaunch) launches++;
    if (obusy) begin
      busy_cnt++;
      if (first_busy < 0) first_busy = cyc;
      last_busy = cyc;
    end
    if (ovalid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_ovalid: ovalid=1 at cycle %0d, required 0", cyc);
      end else begin
        e = exp_q.pop_front();
        check("oresp", 64'(oresp), 64'(e.resp));
        check("ovalid_cycle", 64'(cyc), 64'(e.cycle));
      end
    end
  end

  initial begin
    logic [63:0] seed;
    irst   = 1'b1;
    istart = 1'b0;
    iseed  = '0;
    ibit   = 1'b0;
    repeat (3) @(negedge iclk);
    check("rst_ochal", ochal, 64'h0);
    check("rst_olaunch", 64'(olaunch), 64'h0);
    check("rst_oresp", 64'(oresp), 64'h0);
    check("rst_ovalid", 64'(ovalid), 64'h0);
    check("rst_obusy", 64'(obusy), 64'h0);
    irst = 1'b0;

    prepare(64'h1, 1);
    issue(64'h1, 1'b1, 4'hF);
    wait_done(0);

    prepare(64'h1, 0);
    issue(64'h1, 1'b1, 4'h0);
    wait_done(0);

    prepare(64'h5A5A_0000_0000_0001, 2);
    issue(64'h5A5A_0000_0000_0001, 1'b1, 4'b1010);
    wait_done(0);

    prepare(64'h0, 3);
    issue(64'h0, 1'b1, model_resp);
    check("seed0_chal", chal_seq[1], 64'h2);
    wait_done(0);

    prepare(64'h8000_0000_0000_0000, 3);
    issue(64'h8000_0000_0000_0000, 1'b1, model_resp);
    wait_done(0);

    // istart re-pulsed mid-request must be ignored
    prepare(64'hDEAD_BEEF_0BAD_F00D, 3);
    issue(64'hDEAD_BEEF_0BAD_F00D, 1'b1, model_resp);
    wait_done(20);

    // reset mid-request: abort, no ovalid, outputs cleared
    prepare(64'h1234_5678_9ABC_DEF0, 1);
    issue(64'h1234_5678_9ABC_DEF0, 1'b0, 4'h0);
    while (cyc < start_cyc + 30) @(negedge iclk);
    irst = 1'b1;
    @(negedge iclk);
    irst = 1'b0;
    check("abort_ochal", ochal, 64'h0);
    check("abort_olaunch", 64'(olaunch), 64'h0);
    check("abort_oresp", 64'(oresp), 64'h0);
    check("abort_ovalid", 64'(ovalid), 64'h0);
    check("abort_obusy", 64'(obusy), 64'h0);
    repeat (70) @(negedge iclk);
    check("abort_obusy_later", 64'(obusy), 64'h0);

    prepare(64'h1, 1);
    issue(64'h1, 1'b1, 4'hF);
    wait_done(0);

    for (int t = 0; t < 6; t++) begin
      seed = {$urandom(), $urandom()};
      prepare(seed, 3);
      issue(seed, 1'b1, model_resp);
      wait_done(0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/puf_response_collector.md
Name: puf_response_collector

Overview:
- Controller/consumer stage directly downstream of the arbiter flip-flop at the end of the two racing delay chains.
- Generates challenges from an LFSR and pulses the race launch.
- Samples the arbiter output and majority-votes VOTES repeated evaluations per challenge.
- Shifts voted bits into a RESP_W-bit response word, presented with a one-cycle valid pulse.

Parameters:
- CHAL_W, 64, challenge width driven to the delay chains.
- RESP_W, 32, response bits collected per request.
- VOTES, 5, evaluations per challenge; must be odd and >=1.
- SETTLE, 4, wait cycles after launch before sampling; must be >=3 (covers race time plus 2-FF sync).
- TAP_MASK, 64'hD800_0000_0000_0000, LFSR feedback tap mask (bits 63,62,60,59).

Ports:
- iclk  in  1  clock.
- irst  in  1  reset; synchronous, active-high.
- istart  in  1  request pulse; accepted only in IDLE.
- iseed  in  CHAL_W  initial challenge, captured on accepted istart.
- ibit  in  1  arbiter output; treated as asynchronous and synchronized internally.
- ochal  out  CHAL_W  current challenge.
- olaunch  out  1  one-cycle race launch pulse.
- oresp  out  RESP_W  collected response.
- ovalid  out  1  one-cycle pulse; oresp is new.
- obusy  out  1  high in every state except IDLE.

Behaviour:
- Reset (irst high at a clock edge): state IDLE; all outputs 0; all counters and the shift register cleared. Reset mid-operation aborts with no ovalid; oresp reads 0.
- States: IDLE, LAUNCH, SETTLE, SAMPLE, NEXT, DONE. All outputs are registered Moore outputs.
- IDLE: if istart=1, load ochal=iseed (64'h1 if iseed==0, so the LFSR never locks up), clear vote_cnt, ones_cnt, bit_cnt and shreg, go to LAUNCH. istart is ignored in all other states (no queueing).
- LAUNCH: olaunch=1 for exactly this cycle, then SETTLE.
- SETTLE: stays SETTLE cycles, counting 0..SETTLE-1, then SAMPLE.
- SAMPLE (1 cycle):
  - ones_cnt += synchronized ibit; vote_cnt += 1.
  - If vote_cnt (post-increment) < VOTES, go to LAUNCH with the same challenge; else go to NEXT.
- NEXT (1 cycle):
  - maj = (ones_cnt > VOTES/2); shreg <= {shreg[RESP_W-2:0], maj}, so the first bit ends in the MSB.
  - ochal <= {ochal[CHAL_W-2:0], ^(ochal & TAP_MASK)}.
  - Clear vote_cnt and ones_cnt.
  - If bit_cnt == RESP_W-1, go to DONE; else bit_cnt += 1 and go to LAUNCH.
- DONE (1 cycle): oresp <= final shreg; ovalid=1; go to IDLE. oresp holds until the next DONE or reset.
- ochal changes only on accepted start and in NEXT; it is stable across all votes of one bit.
- Synchronizer: ibit passes through 2 flops; SAMPLE uses the second-stage output.
- Latency: with the istart cycle as cycle 0, ovalid is high in cycle 1 + RESP_W*(VOTES*(SETTLE+2)+1). Defaults give cycle 993.
- Counter widths: $clog2 of the respective maximum +1; no wrap within a request.

Decomposition:
- arbiter_puf_pkg holds:
  - the state enum;
  - the default TAP_MASK constant;
  - a majority function (count, votes) -> bit.
- Sub-module puf_bit_sync: 2-FF synchronizer on iclk with synchronous active-high reset to 0, instantiated for ibit.

Test Plan (RESP_W=4, VOTES=3, SETTLE=3 unless noted):
- ibit tied 1, istart at cycle 0, seed 64'h1 -> olaunch pulses 12 times; ovalid only in cycle 65; oresp=4'hF; obusy high cycles 1..65.
- ibit tied 0 -> oresp=4'h0, ovalid in cycle 65.
- ibit driven 1,1,0 per vote for bits 0 and 2, and 0,0,1 for bits 1 and 3 -> oresp=4'b1010.
- iseed=0 -> ochal=64'h1 in cycle 1; after first NEXT ochal=64'h2. iseed=64'h8000_0000_0000_0000 -> after first NEXT ochal=64'h1.
- istart re-pulsed at cycle 20 -> ignored; ovalid still only in cycle 65; ochal sequence unchanged.
- irst asserted at cycle 30 -> next cycle all outputs 0, state IDLE, no ovalid; a new istart then completes normally with ovalid 65 cycles after it.
